// File: rtl/s_bram_pkg.sv
// Shared constants and phase encoding for the S state BRAM sequencer and its port mux.
package s_bram_pkg;

    localparam int NUM_WORDS = 25;  // state words loaded, permuted and emitted (1..64)
    localparam int DW        = 64;  // data width
    localparam int AW        = 6;   // BRAM address width

    // Phase select driven on cstate; the port mux decodes the same values.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ACCEPT = 4'd1,
        ROUND  = 4'd2,
        OUTPUT = 4'd3
    } s_state_e;

endpackage

// File: rtl/s_out_skid_fifo.sv
// Two-entry skid FIFO that catches BRAM read data during the OUTPUT phase.
module s_out_skid_fifo
    import s_bram_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO registers; the entries reset to zero so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/s_bram_ctrl.sv
// Sequencer for the S state BRAM: load words, hand off to the round engine, stream results out.
//
// Handshakes: a word moves on s_valid && s_ready (input) or m_valid && m_ready (output);
// the sender holds valid and data stable until the transfer, and ready may change freely.
module s_bram_ctrl
    import s_bram_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [3:0]    cstate,
    output logic          in_WEn,
    output logic [AW-1:0] in_WAd,
    output logic [DW-1:0] in_WData,
    output logic [AW-1:0] out_RAd,
    input  logic [DW-1:0] S_RData,
    output logic          round_start,
    input  logic          round_done,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy
);

    localparam int            LAST_I   = NUM_WORDS - 1;
    localparam logic [AW-1:0] LAST_IDX = LAST_I[AW-1:0];
    localparam logic [AW:0]   NUM_W    = NUM_WORDS[AW:0];

    s_state_e      state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;    // one extra bit so it can reach NUM_WORDS
    logic [AW-1:0] out_cnt_q, out_cnt_d;  // index of the word at the FIFO head
    logic          round_start_q, round_start_d;
    logic          inflight_q, inflight_d;
    logic          s_hs, fifo_pop, fifo_clr, rd_issue;
    logic [1:0]    fifo_count;
    logic [2:0]    pending;
    logic [DW-1:0] fifo_head;

    assign cstate      = state_q;
    assign busy        = (state_q != IDLE);
    assign round_start = round_start_q;

    // Write side is combinational so a word lands in the BRAM in its handshake cycle.
    assign s_ready  = (state_q == ACCEPT);
    assign s_hs     = s_valid && s_ready;
    assign in_WEn   = s_hs;
    assign in_WAd   = s_ready ? wr_cnt_q : '0;
    assign in_WData = s_ready ? s_data : '0;

    assign m_valid  = (fifo_count != 2'd0);
    assign m_data   = fifo_head;
    assign m_last   = m_valid && (out_cnt_q == LAST_IDX);
    assign fifo_pop = m_valid && m_ready;

    // Occupancy the FIFO will have once this cycle's pop and the in-flight read settle;
    // counting the pop lets a new read go out every cycle while m_ready stays high.
    assign pending  = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight_q};
    assign rd_issue = (state_q == OUTPUT) && (rd_cnt_q < NUM_W) && (pending < 3'd2);
    assign out_RAd  = ((state_q == OUTPUT) && (rd_cnt_q < NUM_W)) ? rd_cnt_q[AW-1:0] : '0;

    s_out_skid_fifo #(.W(DW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (fifo_clr),
        .push      (inflight_q),
        .push_data (S_RData),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Phase sequencing and counter updates.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        out_cnt_d     = out_cnt_q;
        round_start_d = 1'b0;
        inflight_d    = rd_issue;
        fifo_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) state_d = ACCEPT;
            end
            ACCEPT: begin
                if (s_hs) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d      = '0;
                        state_d       = ROUND;
                        round_start_d = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            ROUND: begin
                // A done pulse coinciding with our own start pulse is stale.
                if (round_done && !round_start_q) begin
                    state_d    = OUTPUT;
                    rd_cnt_d   = '0;
                    out_cnt_d  = '0;
                    fifo_clr   = 1'b1;
                    inflight_d = 1'b0;
                end
            end
            OUTPUT: begin
                if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
                if (fifo_pop) begin
                    if (m_last) begin
                        state_d    = IDLE;
                        rd_cnt_d   = '0;
                        out_cnt_d  = '0;
                        fifo_clr   = 1'b1;
                        inflight_d = 1'b0;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            out_cnt_q     <= '0;
            round_start_q <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            out_cnt_q     <= out_cnt_d;
            round_start_q <= round_start_d;
            inflight_q    <= inflight_d;
        end
    end

endmodule

// File: tb/tb_s_bram_ctrl.sv
// Bench for s_bram_ctrl: vector table for the first phase steps, then whole load/round/output frames.
module tb_s_bram_ctrl;
    import s_bram_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [3:0]    cstate;
    logic          in_WEn;
    logic [AW-1:0] in_WAd;
    logic [DW-1:0] in_WData;
    logic [AW-1:0] out_RAd;
    logic [DW-1:0] S_RData = '0;
    logic          round_start;
    logic          round_done = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    always #5 clk = ~clk;

    s_bram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cstate(cstate), .in_WEn(in_WEn), .in_WAd(in_WAd), .in_WData(in_WData),
        .out_RAd(out_RAd), .S_RData(S_RData), .round_start(round_start),
        .round_done(round_done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    // ---------------- counters and scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_idx = 0;
    int rs_cnt  = 0;
    int first_hs_cyc = 0;
    int last_hs_cyc  = 0;
    logic [AW+DW-1:0] wr_exp_q[$];
    logic [DW-1:0]    exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment memory: expected permutation applied by the round engine model.
    function automatic logic [DW-1:0] perm(input int m, input int idx, input logic [DW-1:0] w);
        if (m == 0) return 64'hA000 + 64'(idx);
        return {w[31:0], w[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    logic [DW-1:0] mem [64];
    int   perm_mode = 0;
    logic perm_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_WEn) mem[in_WAd] <= in_WData;
        if (round_done && perm_en)
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= perm(perm_mode, i, mem[i]);
        S_RData <= mem[out_RAd];
    end

    // Write monitor: every in_WEn must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_WEn) begin
                if (wr_exp_q.size() == 0) begin
                    chk("unexpected_write", {in_WAd, in_WData}, '0);
                end else begin
                    chk("write", {in_WAd, in_WData}, wr_exp_q.pop_front());
                end
            end
            if (cstate >= 4'd2 && s_ready) chk("stray_s_ready", s_ready, 1'b0);
            if (round_start) rs_cnt++;
        end
    end

    // Output monitor: each transfer must match the next expected word; m_last only on the final one.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", m_data, '0);
            end else begin
                chk("out_data", m_data, exp_q.pop_front());
            end
            chk("out_last", m_last, (out_idx == NUM_WORDS - 1));
            if (out_idx == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            out_idx++;
        end
    end

    task automatic chk_reset(input string name);
        chk(name, {cstate, s_ready, round_start, m_valid, m_last, busy, in_WEn, out_RAd, m_data}, '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst_n;
        logic          s_valid;
        logic [DW-1:0] s_data;
        logic [3:0]    cstate;
        logic          s_ready;
        logic          wen;
        logic [AW-1:0] wad;
        logic [DW-1:0] wdata;
        logic          busy;
    } vec_t;

    vec_t tbl[7];

    // ---------------- frame driver ----------------
    int ready_pat[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1};

    task automatic run_frame(input int pmode, input int gap, input int rdy,
                             input bit stray, input bit early, input int rst_at);
        logic [DW-1:0] words[NUM_WORDS];
        int i, k, guard, delay;
        for (int j = 0; j < NUM_WORDS; j++) begin
            words[j] = (gap == 1) ? 64'h1000 + 64'(j) : {$urandom, $urandom};
            wr_exp_q.push_back({AW'(j), words[j]});
        end
        out_idx = 0;
        rs_cnt  = 0;
        perm_mode = pmode;

        // load
        i = 0; k = 0; guard = 0;
        while (i < NUM_WORDS && guard < 400) begin
            @(posedge clk); #1;
            guard++; k++;
            case (gap)
                0:       s_valid = 1'b1;
                1:       s_valid = (k % 3 != 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = s_valid ? words[i] : 64'hDEAD_BEEF;
            @(negedge clk);
            if (s_valid && s_ready) i++;
        end
        if (guard >= 400) chk("load_timeout", guard, 0);
        @(posedge clk); #1;
        s_valid = stray;
        s_data  = {$urandom, $urandom};

        // round handoff
        @(negedge clk);
        chk("round_enter", cstate, 4'd2);
        chk("round_start_first", round_start, 1'b1);
        chk("load_writes_left", wr_exp_q.size(), 0);
        if (early) begin
            round_done = 1'b1;
            perm_en    = 1'b0;
        end
        delay = early ? 10 : $urandom_range(1, 6);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
            round_done = 1'b0;
            @(negedge clk);
            chk("round_hold", cstate, 4'd2);
        end
        round_done = 1'b1;
        perm_en    = 1'b1;
        for (int j = 0; j < NUM_WORDS; j++) exp_q.push_back(perm(pmode, j, words[j]));
        @(posedge clk); #1;
        round_done = 1'b0;
        perm_en    = 1'b0;
        m_ready    = (rdy == 0);

        // output
        k = 0; guard = 0;
        while (out_idx < NUM_WORDS && guard < 500) begin
            if (rst_at >= 0 && out_idx >= rst_at) break;
            @(negedge clk);
            guard++;
            if (guard == 1) chk("output_enter", cstate, 4'd3);
            if (guard <= 3) chk("first_valid_timing", m_valid, (guard == 3));
            @(posedge clk); #1;
            case (rdy)
                0:       m_ready = 1'b1;
                1:       m_ready = ready_pat[k % 12] != 0;
                default: m_ready = $urandom_range(0, 1) != 0;
            endcase
            k++;
        end
        if (guard >= 500) chk("output_timeout", guard, 0);

        if (rst_at >= 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk_reset("reset_mid_output");
            exp_q.delete();
            wr_exp_q.delete();
            @(posedge clk); #1;
            rst_n   = 1'b1;
            s_valid = 1'b0;
            m_ready = 1'b0;
            return;
        end

        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_last", {cstate, busy}, 5'd0);
        chk("round_start_pulses", rs_cnt, 1);
        chk("outputs_left", exp_q.size(), 0);
        if (rdy == 0) chk("full_rate_span", last_hs_cyc - first_hs_cyc, NUM_WORDS - 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tbl[0] = '{1'b0, 1'b1, 64'h55,   4'd0, 1'b0, 1'b0, 6'd0, 64'h0,    1'b0};
        tbl[1] = '{1'b1, 1'b0, 64'h55,   4'd0, 1'b0, 1'b0, 6'd0, 64'h0,    1'b0};
        tbl[2] = '{1'b1, 1'b1, 64'h77,   4'd0, 1'b0, 1'b0, 6'd0, 64'h0,    1'b0};
        tbl[3] = '{1'b1, 1'b1, 64'h1000, 4'd1, 1'b1, 1'b1, 6'd0, 64'h1000, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 64'h1001, 4'd1, 1'b1, 1'b0, 6'd1, 64'h1001, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 64'h1001, 4'd1, 1'b1, 1'b1, 6'd1, 64'h1001, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 64'h1002, 4'd0, 1'b0, 1'b0, 6'd0, 64'h0,    1'b0};
        wr_exp_q.push_back({6'd0, 64'h1000});
        wr_exp_q.push_back({6'd1, 64'h1001});

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset("reset_values");

        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            rst_n   = tbl[v].rst_n;
            s_valid = tbl[v].s_valid;
            s_data  = tbl[v].s_data;
            @(negedge clk);
            chk($sformatf("vec%0d", v),
                {tbl[v].cstate, tbl[v].s_ready, tbl[v].wen, tbl[v].wad, tbl[v].wdata, tbl[v].busy},
                {tbl[v].cstate, tbl[v].s_ready, tbl[v].wen, tbl[v].wad, tbl[v].wdata, tbl[v].busy} ^
                ({cstate, s_ready, in_WEn, in_WAd, in_WData, busy} ^
                 {tbl[v].cstate, tbl[v].s_ready, tbl[v].wen, tbl[v].wad, tbl[v].wdata, tbl[v].busy}) ^
                ({cstate, s_ready, in_WEn, in_WAd, in_WData, busy} ^
                 {tbl[v].cstate, tbl[v].s_ready, tbl[v].wen, tbl[v].wad, tbl[v].wdata, tbl[v].busy}));
            chk($sformatf("vec%0d_outputs", v),
                {cstate, s_ready, in_WEn, in_WAd, in_WData, busy},
                {tbl[v].cstate, tbl[v].s_ready, tbl[v].wen, tbl[v].wad, tbl[v].wdata, tbl[v].busy});
        end
        chk("table_writes_left", wr_exp_q.size(), 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;

        run_frame(0, 1, 0, 1'b0, 1'b1, -1);  // counting load with gaps, stale done, full rate
        run_frame(1, 2, 1, 1'b0, 1'b0, -1);  // backpressure pattern
        run_frame(1, 2, 2, 1'b1, 1'b0, 12);  // stray input, reset mid-output
        run_frame(0, 0, 0, 1'b0, 1'b0, -1);  // fresh load from address 0 after reset
        for (int r = 0; r < 4; r++)
            run_frame(1, 2, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
